// File: rtl/sddr_cmd_phy.sv
// DDR3 command/address PHY: power-up pin sequencing (RESET#, CKE, CK enable)
// followed by a valid/ready command path into a fixed-depth register
// pipeline that drives the command/address pins. Idle cycles issue NOPs.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RESET_LOW  | RESET# and CKE low, CS# high; counting RESET_CYCLES
// CKE_LOW    | RESET# high, CKE low, CS# high; counting CKE_CYCLES
// XPR_WAIT   | CKE high, pipeline issues NOPs; counting XPR_CYCLES
// READY      | commands accepted; terminal until reset
module sddr_cmd_phy #(
  parameter int BANK_BITS    = 3,
  parameter int ADDR_BITS    = 14,
  parameter int CMD_STAGES   = 1,
  parameter int RESET_CYCLES = 40000,
  parameter int CKE_CYCLES   = 100000,
  parameter int XPR_CYCLES   = 64
) (
  input  logic                 in_ddr_clock_i,
  input  logic                 in_phy_reset_n_i,
  input  logic                 ctl_valid_i,
  output logic                 ctl_ready_o,
  input  logic                 ctl_ras_n_i,
  input  logic                 ctl_cas_n_i,
  input  logic                 ctl_we_n_i,
  input  logic [BANK_BITS-1:0] ctl_ba_i,
  input  logic [ADDR_BITS-1:0] ctl_addr_i,
  input  logic                 ctl_odt_i,
  output logic                 phy_init_done_o,
  output logic                 ck_en_o,
  output logic                 ddr3_reset_n_o,
  output logic                 ddr3_cke_o,
  output logic                 ddr3_cs_n_o,
  output logic                 ddr3_ras_n_o,
  output logic                 ddr3_cas_n_o,
  output logic                 ddr3_we_n_o,
  output logic                 ddr3_odt_o,
  output logic [BANK_BITS-1:0] ddr3_ba_o,
  output logic [ADDR_BITS-1:0] ddr3_addr_o
);

  localparam logic [1:0] ST_RESET_LOW = 2'd0;
  localparam logic [1:0] ST_CKE_LOW   = 2'd1;
  localparam logic [1:0] ST_XPR_WAIT  = 2'd2;
  localparam logic [1:0] ST_READY     = 2'd3;

  // One shared down-counter, wide enough for the longest phase.
  localparam int MAX_RC  = (RESET_CYCLES > CKE_CYCLES) ? RESET_CYCLES : CKE_CYCLES;
  localparam int MAX_CNT = (MAX_RC > XPR_CYCLES) ? MAX_RC : XPR_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  // Each phase lasts N edges: load N-1 on entry, leave when the count is 0.
  localparam logic [CNT_W-1:0] LOAD_RESET = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_CKE   = CNT_W'(CKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_XPR   = CNT_W'(XPR_CYCLES - 1);

  // Pipeline entry layout: {cs_n, ras_n, cas_n, we_n, odt, ba, addr}.
  localparam int ENT_W = 5 + BANK_BITS + ADDR_BITS;
  localparam logic [ENT_W-1:0] ENT_IDLE = {4'b1111, 1'b0, {BANK_BITS{1'b0}}, {ADDR_BITS{1'b0}}};

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 reset_n_q, cke_q, ready_q, ck_en_q;
  logic [BANK_BITS-1:0] last_ba_q, last_ba_d;
  logic [ADDR_BITS-1:0] last_addr_q, last_addr_d;
  logic [ENT_W-1:0]     ent_d;
  logic [ENT_W-1:0]     pipe_q [CMD_STAGES];
  logic                 accept;
  logic                 cmd_active;

  // Sequencer next state: count down the current phase, then advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET_LOW: begin
        if (cnt_q == '0) begin
          state_d = ST_CKE_LOW;
          cnt_d   = LOAD_CKE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CKE_LOW: begin
        if (cnt_q == '0) begin
          state_d = ST_XPR_WAIT;
          cnt_d   = LOAD_XPR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_XPR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_RESET_LOW;
        cnt_d   = LOAD_RESET;
      end
    endcase
  end

  // Sequencer state and the registered decodes of the next state, so the
  // pin levels change on the same edge the phase does.
  always_ff @(posedge in_ddr_clock_i) begin
    if (!in_phy_reset_n_i) begin
      state_q   <= ST_RESET_LOW;
      cnt_q     <= LOAD_RESET;
      reset_n_q <= 1'b0;
      cke_q     <= 1'b0;
      ready_q   <= 1'b0;
      ck_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reset_n_q <= (state_d != ST_RESET_LOW);
      cke_q     <= (state_d == ST_XPR_WAIT) || (state_d == ST_READY);
      ready_q   <= (state_d == ST_READY);
      ck_en_q   <= 1'b1;
    end
  end

  // ready_q is exactly "state is READY", so accept never loops back into ready.
  assign accept     = ctl_valid_i && ready_q;
  assign cmd_active = (state_q == ST_XPR_WAIT) || (state_q == ST_READY);

  // Build the stage-0 entry: accepted command, NOP, or pre-CKE idle.
  // BA/ADDR keep the last accepted values so the bus does not toggle on NOPs.
  always_comb begin
    last_ba_d   = last_ba_q;
    last_addr_d = last_addr_q;
    if (accept) begin
      last_ba_d   = ctl_ba_i;
      last_addr_d = ctl_addr_i;
    end
    if (accept) begin
      ent_d = {1'b0, ctl_ras_n_i, ctl_cas_n_i, ctl_we_n_i, ctl_odt_i, ctl_ba_i, ctl_addr_i};
    end else if (cmd_active) begin
      ent_d = {4'b0111, ctl_odt_i && ready_q, last_ba_q, last_addr_q};
    end else begin
      ent_d = {4'b1111, 1'b0, last_ba_q, last_addr_q};
    end
  end

  // Held BA/ADDR for NOP cycles.
  always_ff @(posedge in_ddr_clock_i) begin
    if (!in_phy_reset_n_i) begin
      last_ba_q   <= '0;
      last_addr_q <= '0;
    end else begin
      last_ba_q   <= last_ba_d;
      last_addr_q <= last_addr_d;
    end
  end

  // Command pipeline; reset flushes anything in flight.
  always_ff @(posedge in_ddr_clock_i) begin
    if (!in_phy_reset_n_i) begin
      for (int i = 0; i < CMD_STAGES; i++) begin
        pipe_q[i] <= ENT_IDLE;
      end
    end else begin
      pipe_q[0] <= ent_d;
      for (int i = 1; i < CMD_STAGES; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign ctl_ready_o     = ready_q;
  assign phy_init_done_o = ready_q;
  assign ck_en_o         = ck_en_q;
  assign ddr3_reset_n_o  = reset_n_q;
  assign ddr3_cke_o      = cke_q;

  assign {ddr3_cs_n_o, ddr3_ras_n_o, ddr3_cas_n_o, ddr3_we_n_o,
          ddr3_odt_o, ddr3_ba_o, ddr3_addr_o} = pipe_q[CMD_STAGES-1];

endmodule

// File: tb/tb_sddr_cmd_phy.sv
// Bench for sddr_cmd_phy with R=4, C=6, X=3, CMD_STAGES=2. The reference
// model works purely from edge counts since reset release: it records what
// each edge should put into the pipeline and reads the pins back
// CMD_STAGES-1 edges later.
module tb_sddr_cmd_phy;

  localparam int R  = 4;
  localparam int C  = 6;
  localparam int X  = 3;
  localparam int S  = 2;
  localparam int BB = 3;
  localparam int AB = 14;
  localparam int EW = 5 + BB + AB;
  localparam logic [EW-1:0] IDLE = {4'b1111, 1'b0, {BB{1'b0}}, {AB{1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic ras = 1'b1, cas = 1'b1, we = 1'b1, odt = 1'b0;
  logic [BB-1:0] ba = '0;
  logic [AB-1:0] addr = '0;
  logic ready, done, ck_en, p_reset_n, p_cke, p_cs, p_ras, p_cas, p_we, p_odt;
  logic [BB-1:0] p_ba;
  logic [AB-1:0] p_addr;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int k = 0;
  logic [EW-1:0] ent [0:255];
  logic [BB-1:0] m_ba;
  logic [AB-1:0] m_addr;
  logic [EW+4:0] exp_vec;
  logic [EW+4:0] obs;

  always #5 clk = ~clk;

  sddr_cmd_phy #(
    .BANK_BITS(BB), .ADDR_BITS(AB), .CMD_STAGES(S),
    .RESET_CYCLES(R), .CKE_CYCLES(C), .XPR_CYCLES(X)
  ) dut (
    .in_ddr_clock_i(clk), .in_phy_reset_n_i(rst_n),
    .ctl_valid_i(valid), .ctl_ready_o(ready),
    .ctl_ras_n_i(ras), .ctl_cas_n_i(cas), .ctl_we_n_i(we),
    .ctl_ba_i(ba), .ctl_addr_i(addr), .ctl_odt_i(odt),
    .phy_init_done_o(done), .ck_en_o(ck_en),
    .ddr3_reset_n_o(p_reset_n), .ddr3_cke_o(p_cke), .ddr3_cs_n_o(p_cs),
    .ddr3_ras_n_o(p_ras), .ddr3_cas_n_o(p_cas), .ddr3_we_n_o(p_we),
    .ddr3_odt_o(p_odt), .ddr3_ba_o(p_ba), .ddr3_addr_o(p_addr)
  );

  assign obs = {p_reset_n, p_cke, ck_en, ready, done,
                p_cs, p_ras, p_cas, p_we, p_odt, p_ba, p_addr};

  // Drive one cycle of inputs, advance one rising edge, update the model,
  // and leave time 1 unit after the edge for sampling.
  task automatic tick(input logic rn, input logic v, input logic r, input logic c,
                      input logic w, input logic [BB-1:0] b, input logic [AB-1:0] a,
                      input logic o);
    logic rdy, act, acc;
    logic [EW-1:0] pins;
    @(negedge clk);
    rst_n = rn; valid = v; ras = r; cas = c; we = w; ba = b; addr = a; odt = o;
    @(posedge clk);
    if (!rn) begin
      k = 0;
      m_ba = '0;
      m_addr = '0;
      exp_vec = {5'b00000, IDLE};
    end else begin
      k++;
      rdy = (k > R + C + X);
      act = (k > R + C);
      acc = rdy && v;
      if (acc) begin
        m_ba = b;
        m_addr = a;
        ent[k] = {1'b0, r, c, w, o, b, a};
      end else if (act) begin
        ent[k] = {4'b0111, o && rdy, m_ba, m_addr};
      end else begin
        ent[k] = {4'b1111, 1'b0, m_ba, m_addr};
      end
      pins = (k - S + 1 >= 1) ? ent[k-S+1] : IDLE;
      exp_vec = {(k >= R), (k >= R + C), 1'b1, (k >= R + C + X), (k >= R + C + X), pins};
    end
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BB'($urandom), AB'($urandom), 1'b1);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL reset cyc=%0d got=%h expected=%h", i, obs, exp_vec);
      end
      n_cmp++;
      if ({p_cs, p_ras, ready, ck_en} !== 4'b1100) begin
        n_err++;
        $display("FAIL reset_pins cyc=%0d got=%b expected=1100", i, {p_cs, p_ras, ready, ck_en});
      end
    end
  endtask

  // Power-up with valid held high throughout (early-valid case) and ODT
  // requested from edge 8 on.
  task automatic test_powerup;
    for (int e = 1; e <= R + C + X; e++) begin
      tick(1'b1, 1'b1, 1'b0, 1'($urandom), 1'($urandom), BB'($urandom), AB'($urandom), e >= 8);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL powerup edge=%0d got=%h expected=%h", k, obs, exp_vec);
      end
      if (k == R || k == R - 1) begin
        n_cmp++;
        if (p_reset_n !== (k == R)) begin
          n_err++;
          $display("FAIL reset_n_rise edge=%0d got=%b", k, p_reset_n);
        end
      end
      if (k == R + C + S - 1 || k == R + C + S) begin
        n_cmp++;
        if (p_cs !== (k == R + C + S ? 1'b0 : 1'b1)) begin
          n_err++;
          $display("FAIL cs_fall edge=%0d got=%b", k, p_cs);
        end
      end
    end
  endtask

  task automatic test_single;
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 14'h1A3, 1'b1);
    n_cmp++;
    if (obs !== exp_vec) begin
      n_err++;
      $display("FAIL single_accept edge=%0d got=%h expected=%h", k, obs, exp_vec);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BB'($urandom), AB'($urandom), 1'b1);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL single edge=%0d got=%h expected=%h", k, obs, exp_vec);
      end
      if (i == 0) begin
        n_cmp++;
        if ({p_cs, p_ras, p_cas, p_we, p_odt, p_ba, p_addr} !== {5'b00111, 3'd5, 14'h1A3}) begin
          n_err++;
          $display("FAIL single_act_pins got=%b%b%b%b%b ba=%0d addr=%h",
                   p_cs, p_ras, p_cas, p_we, p_odt, p_ba, p_addr);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 7; i++) begin
      if (i <= 4)
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, BB'($urandom), AB'(i), 1'($urandom));
      else
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL b2b edge=%0d got=%h expected=%h", k, obs, exp_vec);
      end
      if (i >= 2 && i <= 5) begin
        n_cmp++;
        if ({p_cs, p_cas, p_addr} !== {2'b00, AB'(i - 1)}) begin
          n_err++;
          $display("FAIL b2b_seq edge=%0d got cs=%b cas=%b addr=%0d expected addr=%0d",
                   k, p_cs, p_cas, p_addr, i - 1);
        end
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           BB'($urandom), AB'($urandom), 1'($urandom));
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL random edge=%0d got=%h expected=%h", k, obs, exp_vec);
      end
    end
  endtask

  task automatic test_mid_reset;
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0, '0, 1'b0);
    for (int e = 1; e <= 19; e++) begin
      tick(1'b1, 1'b1, 1'b0, 1'($urandom), 1'($urandom), BB'($urandom), AB'($urandom), 1'b1);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL pre_reset edge=%0d got=%h expected=%h", k, obs, exp_vec);
      end
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BB'($urandom), AB'($urandom), 1'b1);
    n_cmp++;
    if (obs !== {5'b00000, IDLE}) begin
      n_err++;
      $display("FAIL mid_reset got=%h expected=%h", obs, {5'b00000, IDLE});
    end
    for (int e = 1; e <= 22; e++) begin
      tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           BB'($urandom), AB'($urandom), 1'($urandom));
      n_cmp++;
      if (obs !== exp_vec) begin
        n_err++;
        $display("FAIL after_reset edge=%0d got=%h expected=%h", k, obs, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_single();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
